// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit: register file, flag-producing ALU and a
// single-entry output buffer with valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter  int WIDTH     = 13,
  parameter  int REG_COUNT = 8,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              imm_en,
  input  logic [WIDTH-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_we,
  output logic [3:0]        out_flags,
  output logic              out_illegal
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_CLR = 4'b0101,
    OP_XOR = 4'b0110,
    OP_SHL = 4'b0111,
    OP_SHR = 4'b1000,
    OP_ADC = 4'b1001,
    OP_CMP = 4'b1010,
    OP_MOV = 4'b1011
  } op_e;

  logic [WIDTH-1:0] regs [REG_COUNT];
  logic [3:0]       flags;

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   ext;
  logic [3:0]       next_flags;
  logic             writes;
  logic             illegal;
  logic             write_en;
  logic             shift_oob;
  logic [SH_W-1:0]  shamt;

  assign in_ready = rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign op_a = (rs1 == '0) ? '0 : regs[rs1];
  assign op_b = imm_en ? imm : ((rs2 == '0) ? '0 : regs[rs2]);

  assign shift_oob = (op_b >= WIDTH'(WIDTH));
  assign shamt     = op_b[SH_W-1:0];

  // Flags are {Z,N,C,V}; C and V are cleared by logic/shift/move ops.
  always_comb begin
    ext        = '0;
    result     = '0;
    next_flags = flags;
    writes     = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_ADC: begin
        ext = {1'b0, op_a} + {1'b0, op_b};
        if (opcode == OP_ADC) ext = ext + {{WIDTH{1'b0}}, flags[1]};
        result        = ext[WIDTH-1:0];
        writes        = 1'b1;
        next_flags[1] = ext[WIDTH];
        next_flags[0] = (op_a[MSB] == op_b[MSB]) && (result[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        ext           = {1'b0, op_a} - {1'b0, op_b};
        result        = ext[WIDTH-1:0];
        writes        = (opcode == OP_SUB);
        next_flags[1] = !ext[WIDTH];
        next_flags[0] = (op_a[MSB] != op_b[MSB]) && (result[MSB] != op_a[MSB]);
      end
      OP_AND, OP_OR, OP_XOR, OP_MOV, OP_CLR, OP_SHL, OP_SHR: begin
        case (opcode)
          OP_AND:  result = op_a & op_b;
          OP_OR:   result = op_a | op_b;
          OP_XOR:  result = op_a ^ op_b;
          OP_MOV:  result = op_b;
          OP_SHL:  result = shift_oob ? '0 : (op_a << shamt);
          OP_SHR:  result = shift_oob ? '0 : (op_a >> shamt);
          default: result = '0;
        endcase
        writes        = 1'b1;
        next_flags[1] = 1'b0;
        next_flags[0] = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
    if (writes || opcode == OP_CMP) begin
      next_flags[3] = (result == '0);
      next_flags[2] = result[MSB];
    end
  end

  assign write_en = writes && (rd != '0);

  // Commit and buffer load share the accept edge, so a dependent op issued on
  // the next cycle already sees the new register and flag values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      flags       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_flags   <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        if (write_en) regs[rd] <= result;
        flags       <= next_flags;
        out_valid   <= 1'b1;
        out_result  <= result;
        out_rd      <= rd;
        out_we      <= write_en;
        out_flags   <= next_flags;
        out_illegal <= illegal;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a behavioural model predicts each beat
// at issue time and the monitor compares beats as the consumer takes them.
module tb_alu_exec_unit;

  localparam int W  = 13;
  localparam int RC = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [AW-1:0] rd, rs1, rs2;
  logic          imm_en;
  logic [W-1:0]  imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [AW-1:0] out_rd;
  logic          out_we;
  logic [3:0]    out_flags;
  logic          out_illegal;

  typedef struct {
    logic [W-1:0]  result;
    logic [AW-1:0] rd;
    logic          we;
    logic [3:0]    flags;
    logic          ill;
  } beat_t;

  beat_t        scoreboard [$];
  logic [W-1:0] mregs [RC];
  logic [3:0]   mflags;
  int           tests = 0;
  int           fails = 0;
  int           last_wait = 0;

  alu_exec_unit #(.WIDTH(W), .REG_COUNT(RC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm_en(imm_en), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_flags(out_flags), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model in plain integer arithmetic, signed overflow by range.
  function automatic beat_t predict(input logic [3:0] op, input logic [AW-1:0] d, s1, s2,
                                    input logic ie, input logic [W-1:0] im);
    int ua, ub, res, sa, sbv, sres;
    int lim = 2 ** W;
    int smax = 2 ** (W - 1) - 1;
    int smin = -(2 ** (W - 1));
    logic wr, z, n, c, v, upd, ill;
    beat_t bt;
    ua  = (s1 == 0) ? 0 : int'(mregs[s1]);
    ub  = ie ? int'(im) : ((s2 == 0) ? 0 : int'(mregs[s2]));
    sa  = (ua > smax) ? ua - lim : ua;
    sbv = (ub > smax) ? ub - lim : ub;
    z = mflags[3]; n = mflags[2]; c = mflags[1]; v = mflags[0];
    wr = 1'b0; upd = 1'b1; ill = 1'b0; res = 0;
    case (op)
      4'd1, 4'd9: begin
        res  = ua + ub + ((op == 4'd9) ? int'(mflags[1]) : 0);
        sres = sa + sbv + ((op == 4'd9) ? int'(mflags[1]) : 0);
        c = (res >= lim); v = (sres > smax) || (sres < smin); wr = 1'b1;
      end
      4'd2, 4'd10: begin
        res = ua - ub; sres = sa - sbv;
        c = (ua >= ub); v = (sres > smax) || (sres < smin); wr = (op == 4'd2);
      end
      4'd3:  begin res = ua & ub; c = 0; v = 0; wr = 1; end
      4'd4:  begin res = ua | ub; c = 0; v = 0; wr = 1; end
      4'd5:  begin res = 0;       c = 0; v = 0; wr = 1; end
      4'd6:  begin res = ua ^ ub; c = 0; v = 0; wr = 1; end
      4'd7:  begin res = (ub >= W) ? 0 : (ua << ub); c = 0; v = 0; wr = 1; end
      4'd8:  begin res = (ub >= W) ? 0 : (ua >> ub); c = 0; v = 0; wr = 1; end
      4'd11: begin res = ub;      c = 0; v = 0; wr = 1; end
      4'd0:  upd = 1'b0;
      default: begin upd = 1'b0; ill = 1'b1; end
    endcase
    res = res & (lim - 1);
    if (upd) begin
      z = (res == 0);
      n = ((res >> (W - 1)) & 1) == 1;
      mflags = {z, n, c, v};
    end
    if (wr && d != 0) mregs[d] = W'(res);
    bt.result = W'(res);
    bt.rd     = d;
    bt.we     = wr && (d != 0);
    bt.flags  = mflags;
    bt.ill    = ill;
    return bt;
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [AW-1:0] d, s1, s2,
                               input logic ie, input logic [W-1:0] im);
    int waits = 0;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm_en = ie; imm = im;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_wait = waits;
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    scoreboard.push_back(predict(op, d, s1, s2, ie, im));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Consumer side: a beat is taken at the next rising edge when out_ready is high.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        beat_t bt;
        bt = scoreboard.pop_front();
        checkOutput("beat_result",  32'(out_result),  32'(bt.result));
        checkOutput("beat_rd",      32'(out_rd),      32'(bt.rd));
        checkOutput("beat_we",      32'(out_we),      32'(bt.we));
        checkOutput("beat_flags",   32'(out_flags),   32'(bt.flags));
        checkOutput("beat_illegal", 32'(out_illegal), 32'(bt.ill));
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    imm_en = 1'b0; imm = '0; out_ready = 1'b1;
    for (int i = 0; i < RC; i++) mregs[i] = '0;
    mflags = '0;

    #2;
    checkOutput("rst_out_valid",   32'(out_valid),   32'd0);
    checkOutput("rst_in_ready",    32'(in_ready),    32'd0);
    checkOutput("rst_out_result",  32'(out_result),  32'd0);
    checkOutput("rst_out_rd",      32'(out_rd),      32'd0);
    checkOutput("rst_out_we",      32'(out_we),      32'd0);
    checkOutput("rst_out_flags",   32'(out_flags),   32'd0);
    checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Carry/overflow into the sign bit, then carry-in chaining.
    applyStimulus(4'b1011, 3'd1, 3'd0, 3'd0, 1'b1, 13'h0FFF);
    applyStimulus(4'b0001, 3'd2, 3'd1, 3'd0, 1'b1, 13'h0001);
    applyStimulus(4'b0001, 3'd3, 3'd0, 3'd0, 1'b1, 13'h1FFF);
    applyStimulus(4'b1001, 3'd4, 3'd3, 3'd0, 1'b1, 13'h0001);
    applyStimulus(4'b1010, 3'd1, 3'd1, 3'd0, 1'b1, 13'h0FFF);
    applyStimulus(4'b0100, 3'd0, 3'd1, 3'd0, 1'b1, 13'h0000);
    applyStimulus(4'b0010, 3'd5, 3'd0, 3'd0, 1'b1, 13'h0001);
    applyStimulus(4'b1011, 3'd0, 3'd0, 3'd0, 1'b1, 13'h0005);
    applyStimulus(4'b0001, 3'd6, 3'd0, 3'd0, 1'b0, 13'h0000);
    applyStimulus(4'b1110, 3'd2, 3'd1, 3'd2, 1'b0, 13'h0000);

    // Back-pressure: the illegal beat must stay put and block the next op.
    out_ready = 1'b0;
    opcode = 4'b0110; rd = 3'd7; rs1 = 3'd2; rs2 = 3'd0; imm_en = 1'b1; imm = 13'h0003;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready),    32'd0);
      checkOutput("stall_valid",    32'(out_valid),   32'd1);
      checkOutput("stall_result",   32'(out_result),  32'(scoreboard[0].result));
      checkOutput("stall_illegal",  32'(out_illegal), 32'(scoreboard[0].ill));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(4'b0110, 3'd7, 3'd2, 3'd0, 1'b1, 13'h0003);
    applyStimulus(4'b0100, 3'd0, 3'd7, 3'd0, 1'b1, 13'h0000);
    checkOutput("stream_wait", 32'(last_wait), 32'd0);
    applyStimulus(4'b0111, 3'd1, 3'd1, 3'd0, 1'b1, 13'd13);
    checkOutput("stream_wait", 32'(last_wait), 32'd0);
    applyStimulus(4'b1000, 3'd3, 3'd2, 3'd0, 1'b1, 13'd12);
    checkOutput("stream_wait", 32'(last_wait), 32'd0);

    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)));
    end
    for (int r = 1; r < RC; r++) applyStimulus(4'b0100, 3'd0, 3'(r), 3'd0, 1'b1, 13'h0000);

    // Reset with a beat still pending in the buffer.
    applyStimulus(4'b0001, 3'd7, 3'd1, 3'd2, 1'b0, 13'h0000);
    out_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("midrst_flags",     32'(out_flags), 32'd0);
    scoreboard.delete();
    for (int i = 0; i < RC; i++) mregs[i] = '0;
    mflags = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int r = 1; r < RC; r++) begin
      applyStimulus(4'b0100, 3'd0, 3'(r), 3'd0, 1'b1, 13'h0000);
      if (r == 1) checkOutput("first_accept_wait", 32'(last_wait), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, registered successor to the 13-bit combinational ALU. It combines a register file, an extended ALU with status flags, and a single-entry output buffer with valid/ready handshakes on both sides. It sits between instruction decode (upstream, issues one op per handshake) and the writeback/trace consumer (downstream). Each accepted op reads operands, computes, and commits to the register file and flags in one clock.

## Interface
- WIDTH, 13: datapath and register width; must be ≥4.
- REG_COUNT, 8: number of registers; power of 2, ≥2. Local ADDR_W = clog2(REG_COUNT); SH_W = clog2(WIDTH).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; **asynchronous, active-low** (assert at 0; all state clears immediately).
- in_valid  in  1  upstream op present.
- in_ready  out  1  unit can accept; = rst high && (!out_valid || out_ready).
- opcode  in  4  operation select (below).
- rd, rs1, rs2  in  ADDR_W each  destination and source register indices.
- imm_en  in  1  1: operand B = imm; 0: operand B = R[rs2].
- imm  in  WIDTH  immediate operand.
- out_valid  out  1  result beat held in output buffer.
- out_ready  in  1  downstream accepts beat.
- out_result  out  WIDTH  computed result.
- out_rd  out  ADDR_W  destination of the beat.
- out_we  out  1  1 if the beat's result was written to the register file.
- out_flags  out  4  {Z,N,C,V} after this op.
- out_illegal  out  1  beat came from an undefined opcode.

## Operation
- Accept = in_valid && in_ready. On accept edge: operands read (A = R[rs1], B = imm_en ? imm : R[rs2]), result computed, register file and flags updated, output buffer loaded, out_valid set.
- R0 reads as 0; writes to R0 discarded (out_we = 0 when rd = 0).
- Opcodes (all arithmetic mod 2^WIDTH):
  - 0000 NOP: result 0, no write, flags unchanged.
  - 0001 ADD A+B; 0010 SUB A−B; 1001 ADC A+B+C: update Z,N,C,V. C = carry out (ADD/ADC); C = no-borrow (A ≥ B unsigned) for SUB. V = signed overflow.
  - 0011 AND, 0100 OR, 0110 XOR, 1011 MOV (result = B), 0101 CLR (result 0): Z,N updated; C,V cleared.
  - 0111 SHL, 1000 SHR (logical): shift A by B interpreted unsigned; B ≥ WIDTH gives 0. Z,N updated; C,V cleared.
  - 1010 CMP: SUB flags computed and stored; no register write; result = A−B.
  - 1100–1111: illegal; behave as NOP with out_illegal = 1.
- Writing ops: 0001–1001 and 1011 (excluding 1010) with rd ≠ 0.
- Flags: Z = (result == 0); N = result[WIDTH−1]; out_flags reflects flags register after the op (unchanged value for NOP/illegal).
- Dependent back-to-back ops need no forwarding: commit precedes next accept edge.
- Output buffer: cleared (out_valid 0) on out_valid && out_ready without simultaneous accept; simultaneous pop and accept reloads with the new beat, out_valid stays 1.

## Timing
- Latency: op accepted at edge N → beat visible with out_valid = 1 after edge N; register/flag effects visible to an op accepted at edge N+1.
- Throughput: one op per cycle while out_ready = 1; with out_ready = 0 and out_valid = 1, in_ready = 0 (combinational from out_ready).
- out_* fields stable while out_valid && !out_ready.
- Reset values: all registers 0, flags 0000, out_valid 0, out_result 0, out_rd 0, out_we 0, out_flags 0, out_illegal 0; in_ready 0 while rst = 0.
- Reset mid-operation: pending beat discarded; no partial write; first accept possible on first edge with rst = 1.

## Test plan
- Reset then MOV R1←imm 0x0FFF, ADD R2←R1+imm 1 (WIDTH 13) → beat 2: result 0x1000, flags Z0 N1 C0 V1; R2 = 0x1000.
- ADD R3←imm 0x1FFF + R0 then ADC R4←R3+imm 1 → first: C0; second: result 0x0000 with C from previous add (0) applied, flags Z1 C1.
- CMP R1 vs imm 0x0FFF → result 0, Z1 C1, out_we 0, R1 unchanged; SUB R5←R0−imm 1 → 0x1FFF, C0 N1.
- Write R0 with MOV imm 5 then ADD R6←R0+R0 → out_we 0, R6 = 0; opcode 1110 → out_illegal 1, flags unchanged.
- Hold out_ready = 0 with in_valid = 1 for 3 cycles → in_ready 0, beat stable, no further register writes; release → one op accepted per cycle.
- SHL R1 by imm 13 → 0; SHR 0x1000 by 12 → 1; assert rst low mid-stream → out_valid 0 and all registers 0 immediately.
